// File: rtl/arm_shift_pkg.sv
// Shared constants and types for the ARM7 operand-2 shifter front end:
// shift encodings, controller states and operand-2 field positions.
`timescale 1ns/1ps
package arm_shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RS_WAIT = 2'd1,
        OUT     = 2'd2
    } state_e;

    localparam int OP2_I_BIT   = 25;
    localparam int OP2_REG_BIT = 4;
    localparam int AMT_HI      = 11;
    localparam int AMT_LO      = 7;
    localparam int TYPE_HI     = 6;
    localparam int TYPE_LO     = 5;
    localparam int RS_HI       = 11;
    localparam int RS_LO       = 8;
    localparam int ROT_HI      = 11;
    localparam int ROT_LO      = 8;
    localparam int IMM_HI      = 7;
    localparam int IMM_LO      = 0;

endpackage

// File: rtl/Barrel_Shifter.sv
// Combinational ARM barrel shifter with the instruction-encoding meaning of a
// zero amount: LSL#0 passes through, LSR#0/ASR#0 shift by 32, ROR#0 is RRX.
`timescale 1ns/1ps
module Barrel_Shifter
    import arm_shift_pkg::*;
(
    input  logic        enable_i,
    input  logic [1:0]  type_i,
    input  logic [4:0]  amount_i,
    input  logic [31:0] din_i,
    input  logic        cin_i,
    output logic [31:0] dout_o,
    output logic        cout_o
);

    logic [4:0] amt_m1_s;
    logic [4:0] amt_neg_s;

    assign amt_m1_s  = amount_i - 5'd1;
    assign amt_neg_s = 5'd0 - amount_i;

    // Shift/rotate selection; carry is the last bit shifted out.
    always_comb begin
        dout_o = din_i;
        cout_o = cin_i;
        if (enable_i) begin
            case (type_i)
                SH_LSL: begin
                    if (amount_i == 5'd0) begin
                        dout_o = din_i;
                        cout_o = cin_i;
                    end else begin
                        dout_o = din_i << amount_i;
                        cout_o = din_i[amt_neg_s];
                    end
                end
                SH_LSR: begin
                    if (amount_i == 5'd0) begin
                        dout_o = 32'd0;
                        cout_o = din_i[31];
                    end else begin
                        dout_o = din_i >> amount_i;
                        cout_o = din_i[amt_m1_s];
                    end
                end
                SH_ASR: begin
                    if (amount_i == 5'd0) begin
                        dout_o = {32{din_i[31]}};
                        cout_o = din_i[31];
                    end else begin
                        dout_o = $signed(din_i) >>> amount_i;
                        cout_o = din_i[amt_m1_s];
                    end
                end
                SH_ROR: begin
                    if (amount_i == 5'd0) begin
                        dout_o = {cin_i, din_i[31:1]};
                        cout_o = din_i[0];
                    end else begin
                        dout_o = (din_i >> amount_i) | (din_i << amt_neg_s);
                        cout_o = din_i[amt_m1_s];
                    end
                end
                default: begin
                    dout_o = din_i;
                    cout_o = cin_i;
                end
            endcase
        end else begin
            dout_o = din_i;
            cout_o = cin_i;
        end
    end

endmodule

// File: rtl/shift_operand_ctrl.sv
// Operand-2 front end: captures a decoded instruction, optionally fetches Rs,
// drives the barrel shifter, fixes up shift-by-register amounts >= 32 and
// presents a registered operand/carry to the ALU over valid/ready.
`timescale 1ns/1ps
module shift_operand_ctrl
    import arm_shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rm,
    input  logic        in_cflag,
    output logic        rs_req,
    output logic [3:0]  rs_addr,
    input  logic        rs_ack,
    input  logic [31:0] rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_operand,
    output logic        out_cout
);

    state_e      state_q, state_d;
    logic [11:0] op2_q, op2_d;
    logic        imm_q, imm_d;
    logic [31:0] rm_q, rm_d;
    logic        c_q, c_d;
    logic        rs_req_q, rs_req_d;
    logic [3:0]  rs_addr_q, rs_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_operand_q, out_operand_d;
    logic        out_cout_q, out_cout_d;

    logic        accept_s;
    logic [11:0] src_op2_s;
    logic        src_imm_s;
    logic [31:0] src_rm_s;
    logic        src_c_s;
    logic [7:0]  n_s;
    logic [1:0]  sh_type_s;
    logic        bs_en_s;
    logic [1:0]  bs_type_s;
    logic [4:0]  bs_amount_s;
    logic [31:0] bs_din_s;
    logic [31:0] bs_dout_s;
    logic        bs_cout_s;
    logic [31:0] result_s;
    logic        result_cout_s;
    logic        unused_s;

    assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign n_s       = rs_data[7:0];
    assign sh_type_s = src_op2_s[TYPE_HI:TYPE_LO];
    assign unused_s  = ^{in_instr[31:26], in_instr[24:12], rs_data[31:8]};

    // Immediate forms complete on the accept edge, so they read the live
    // inputs; register shifts complete later from the captured copies.
    always_comb begin
        if (state_q == RS_WAIT) begin
            src_op2_s = op2_q;
            src_imm_s = imm_q;
            src_rm_s  = rm_q;
            src_c_s   = c_q;
        end else begin
            src_op2_s = in_instr[11:0];
            src_imm_s = in_instr[OP2_I_BIT];
            src_rm_s  = in_rm;
            src_c_s   = in_cflag;
        end
    end

    // Shifter operand mux for the three operand-2 forms.
    always_comb begin
        bs_en_s     = 1'b1;
        bs_type_s   = sh_type_s;
        bs_amount_s = src_op2_s[AMT_HI:AMT_LO];
        bs_din_s    = src_rm_s;
        if (src_imm_s) begin
            bs_en_s     = |src_op2_s[ROT_HI:ROT_LO];
            bs_type_s   = SH_ROR;
            bs_amount_s = {src_op2_s[ROT_HI:ROT_LO], 1'b0};
            bs_din_s    = {24'd0, src_op2_s[IMM_HI:IMM_LO]};
        end else if (src_op2_s[OP2_REG_BIT]) begin
            bs_en_s     = |n_s[4:0];
            bs_type_s   = sh_type_s;
            bs_amount_s = n_s[4:0];
            bs_din_s    = src_rm_s;
        end else begin
            bs_en_s     = 1'b1;
            bs_type_s   = sh_type_s;
            bs_amount_s = src_op2_s[AMT_HI:AMT_LO];
            bs_din_s    = src_rm_s;
        end
    end

    Barrel_Shifter u_shifter (
        .enable_i (bs_en_s),
        .type_i   (bs_type_s),
        .amount_i (bs_amount_s),
        .din_i    (bs_din_s),
        .cin_i    (src_c_s),
        .dout_o   (bs_dout_s),
        .cout_o   (bs_cout_s)
    );

    // Register-specified amounts beyond the shifter's 5-bit range.
    always_comb begin
        result_s      = bs_dout_s;
        result_cout_s = bs_cout_s;
        if (!src_imm_s && src_op2_s[OP2_REG_BIT] && (n_s != 8'd0)) begin
            case (sh_type_s)
                SH_LSL: begin
                    if (n_s == 8'd32) begin
                        result_s      = 32'd0;
                        result_cout_s = src_rm_s[0];
                    end else if (n_s > 8'd32) begin
                        result_s      = 32'd0;
                        result_cout_s = 1'b0;
                    end else begin
                        result_s      = bs_dout_s;
                        result_cout_s = bs_cout_s;
                    end
                end
                SH_LSR: begin
                    if (n_s == 8'd32) begin
                        result_s      = 32'd0;
                        result_cout_s = src_rm_s[31];
                    end else if (n_s > 8'd32) begin
                        result_s      = 32'd0;
                        result_cout_s = 1'b0;
                    end else begin
                        result_s      = bs_dout_s;
                        result_cout_s = bs_cout_s;
                    end
                end
                SH_ASR: begin
                    if (n_s >= 8'd32) begin
                        result_s      = {32{src_rm_s[31]}};
                        result_cout_s = src_rm_s[31];
                    end else begin
                        result_s      = bs_dout_s;
                        result_cout_s = bs_cout_s;
                    end
                end
                SH_ROR: begin
                    if (n_s[4:0] == 5'd0) begin
                        result_s      = src_rm_s;
                        result_cout_s = src_rm_s[31];
                    end else begin
                        result_s      = bs_dout_s;
                        result_cout_s = bs_cout_s;
                    end
                end
                default: begin
                    result_s      = bs_dout_s;
                    result_cout_s = bs_cout_s;
                end
            endcase
        end else begin
            result_s      = bs_dout_s;
            result_cout_s = bs_cout_s;
        end
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d       = state_q;
        op2_d         = op2_q;
        imm_d         = imm_q;
        rm_d          = rm_q;
        c_d           = c_q;
        rs_req_d      = rs_req_q;
        rs_addr_d     = rs_addr_q;
        out_valid_d   = out_valid_q;
        out_operand_d = out_operand_q;
        out_cout_d    = out_cout_q;
        case (state_q)
            IDLE, OUT: begin
                if (accept_s) begin
                    op2_d = in_instr[11:0];
                    imm_d = in_instr[OP2_I_BIT];
                    rm_d  = in_rm;
                    c_d   = in_cflag;
                    if (in_instr[OP2_I_BIT] || !in_instr[OP2_REG_BIT]) begin
                        state_d       = OUT;
                        out_valid_d   = 1'b1;
                        out_operand_d = result_s;
                        out_cout_d    = result_cout_s;
                    end else begin
                        state_d     = RS_WAIT;
                        rs_req_d    = 1'b1;
                        rs_addr_d   = in_instr[RS_HI:RS_LO];
                        out_valid_d = 1'b0;
                    end
                end else if ((state_q == OUT) && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RS_WAIT: begin
                if (rs_ack) begin
                    state_d       = OUT;
                    rs_req_d      = 1'b0;
                    out_valid_d   = 1'b1;
                    out_operand_d = result_s;
                    out_cout_d    = result_cout_s;
                end else begin
                    state_d = RS_WAIT;
                end
            end
            default: begin
                state_d     = IDLE;
                rs_req_d    = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op2_q         <= 12'd0;
            imm_q         <= 1'b0;
            rm_q          <= 32'd0;
            c_q           <= 1'b0;
            rs_req_q      <= 1'b0;
            rs_addr_q     <= 4'd0;
            out_valid_q   <= 1'b0;
            out_operand_q <= 32'd0;
            out_cout_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op2_q         <= op2_d;
            imm_q         <= imm_d;
            rm_q          <= rm_d;
            c_q           <= c_d;
            rs_req_q      <= rs_req_d;
            rs_addr_q     <= rs_addr_d;
            out_valid_q   <= out_valid_d;
            out_operand_q <= out_operand_d;
            out_cout_q    <= out_cout_d;
        end
    end

    assign rs_req      = rs_req_q;
    assign rs_addr     = rs_addr_q;
    assign out_valid   = out_valid_q;
    assign out_operand = out_operand_q;
    assign out_cout    = out_cout_q;

endmodule

// File: tb/tb_shift_operand_ctrl.sv
// Directed bench for shift_operand_ctrl: hand-computed operand/carry vectors
// plus handshake, backpressure and reset-in-flight scenarios.
`timescale 1ns/1ps
module tb_shift_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rm;
    logic        in_cflag;
    logic        rs_req;
    logic [3:0]  rs_addr;
    logic        rs_ack;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operand;
    logic        out_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_operand_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rm       (in_rm),
        .in_cflag    (in_cflag),
        .rs_req      (rs_req),
        .rs_addr     (rs_addr),
        .rs_ack      (rs_ack),
        .rs_data     (rs_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_cout    (out_cout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] rm, input logic c);
        in_valid = 1'b1;
        in_instr = instr;
        in_rm    = rm;
        in_cflag = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_imm(input string tag, input logic [31:0] instr, input logic [31:0] rm,
                           input logic c, input logic [31:0] exp_op, input logic exp_c);
        check_val({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        issue(instr, rm, c);
        check_val({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, ".operand"}, out_operand, exp_op);
        check_val({tag, ".cout"}, {31'd0, out_cout}, {31'd0, exp_c});
    endtask

    task automatic run_reg(input string tag, input logic [31:0] instr, input logic [31:0] rm,
                           input logic c, input logic [31:0] rs, input int delay,
                           input logic [31:0] exp_op, input logic exp_c);
        issue(instr, rm, c);
        check_val({tag, ".rs_req"}, {31'd0, rs_req}, 32'd1);
        check_val({tag, ".rs_addr"}, {28'd0, rs_addr}, {28'd0, instr[11:8]});
        check_val({tag, ".wait_valid"}, {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            rs_data = 32'hDEAD_BEEF;
            tick();
            check_val({tag, ".rs_req_hold"}, {31'd0, rs_req}, 32'd1);
            check_val({tag, ".rs_addr_hold"}, {28'd0, rs_addr}, {28'd0, instr[11:8]});
            check_val({tag, ".wait_valid_hold"}, {31'd0, out_valid}, 32'd0);
        end
        rs_ack  = 1'b1;
        rs_data = rs;
        tick();
        rs_ack  = 1'b0;
        rs_data = 32'h1234_5678;
        check_val({tag, ".rs_req_drop"}, {31'd0, rs_req}, 32'd0);
        check_val({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, ".operand"}, out_operand, exp_op);
        check_val({tag, ".cout"}, {31'd0, out_cout}, {31'd0, exp_c});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, ".rs_req"}, {31'd0, rs_req}, 32'd0);
        check_val({tag, ".rs_addr"}, {28'd0, rs_addr}, 32'd0);
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, ".out_operand"}, out_operand, 32'd0);
        check_val({tag, ".out_cout"}, {31'd0, out_cout}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_rm     = 32'd0;
        in_cflag  = 1'b0;
        rs_ack    = 1'b0;
        rs_data   = 32'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Immediates, back-to-back with out_ready high.
        run_imm("imm_4ff", 32'h0200_04FF, 32'h0, 1'b0, 32'hFF00_0000, 1'b1);
        run_imm("imm_0ab_c1", 32'h0200_00AB, 32'h0, 1'b1, 32'h0000_00AB, 1'b1);
        run_imm("imm_0ab_c0", 32'h0200_00AB, 32'h0, 1'b0, 32'h0000_00AB, 1'b0);
        run_imm("imm_f01", 32'h0200_0F01, 32'h0, 1'b1, 32'h0000_0004, 1'b0);

        // Shift by immediate.
        run_imm("lsr0", 32'h0000_0020, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
        run_imm("rrx", 32'h0000_0060, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        run_imm("lsl4", 32'h0000_0200, 32'h1000_0001, 1'b0, 32'h0000_0010, 1'b1);
        run_imm("asr4", 32'h0000_0240, 32'h8000_0000, 1'b1, 32'hF800_0000, 1'b0);
        run_imm("lsr1", 32'h0000_00A0, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1);

        // Shift by register.
        run_reg("lsl_r32", 32'h0000_0310, 32'h1, 1'b0, 32'd32, 0, 32'h0, 1'b1);
        run_reg("lsl_r33", 32'h0000_0310, 32'h1, 1'b1, 32'd33, 1, 32'h0, 1'b0);
        run_reg("lsl_r100_c1", 32'h0000_0310, 32'h1, 1'b1, 32'h100, 0, 32'h1, 1'b1);
        run_reg("lsl_r100_c0", 32'h0000_0310, 32'h1, 1'b0, 32'h100, 0, 32'h1, 1'b0);
        run_reg("lsl_r4", 32'h0000_0A10, 32'h1000_0001, 1'b1, 32'd4, 0, 32'h10, 1'b1);
        run_reg("asr_r40", 32'h0000_0550, 32'h8000_0000, 1'b0, 32'd40, 4, 32'hFFFF_FFFF, 1'b1);
        run_reg("ror_r64", 32'h0000_0370, 32'h8000_0001, 1'b0, 32'd64, 0, 32'h8000_0001, 1'b1);
        run_reg("ror_r36", 32'h0000_0370, 32'h8000_0001, 1'b1, 32'd36, 0, 32'h1800_0000, 1'b0);
        run_reg("lsr_r32", 32'h0000_0C30, 32'h8000_0000, 1'b0, 32'd32, 2, 32'h0, 1'b1);
        run_reg("lsr_r32_b7", 32'h0000_03B0, 32'h7FFF_FFFF, 1'b1, 32'd32, 0, 32'h0, 1'b0);
        run_reg("lsr_r40", 32'h0000_0330, 32'h8000_0000, 1'b1, 32'd40, 0, 32'h0, 1'b0);

        tick();
        check_val("drain.valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A held while B waits, B accepted the cycle out_ready rises.
        out_ready = 1'b0;
        issue(32'h0200_04FF, 32'h0, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h0200_00AB;
        in_cflag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("bp.in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp.valid", {31'd0, out_valid}, 32'd1);
            check_val("bp.operand", out_operand, 32'hFF00_0000);
            check_val("bp.cout", {31'd0, out_cout}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp.in_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("bp.next_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp.next_operand", out_operand, 32'h0000_00AB);
        tick();

        // Reset while an Rs read is outstanding.
        issue(32'h0000_0710, 32'h1, 1'b1);
        check_val("rstw.rs_req", {31'd0, rs_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rstw.async");
        tick();
        rst = 1'b0;
        rs_ack  = 1'b1;
        rs_data = 32'd1;
        tick();
        rs_ack = 1'b0;
        check_val("rstw.late_ack_valid", {31'd0, out_valid}, 32'd0);
        check_val("rstw.late_ack_req", {31'd0, rs_req}, 32'd0);
        run_imm("rstw.imm", 32'h0200_04FF, 32'h0, 1'b0, 32'hFF00_0000, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
